// File: rtl/simple_uart.sv
// simple_uart: 8N1 UART with a programmable 32-bit baud divider.
// Each bit lasts DIV+1 clock cycles. TX writes stall the bus while the transmitter is
// busy. RX has a single-byte holding buffer with no overrun flag.
//
// Ports:
//   clk, reset    system clock (rising edge), asynchronous active-high reset
//   ser_tx        serial TX line, idle high
//   ser_rx        serial RX line, idle high, already synchronous to clk
//   reg_div_we    per-byte write enables for DIV
//   reg_div_di    DIV write data
//   reg_div_do    current DIV value
//   reg_dat_we    write TX byte from reg_dat_di[7:0]
//   reg_dat_re    read strobe, consumes the RX buffer
//   reg_dat_di    TX write data, only [7:0] used
//   reg_dat_do    {24'h0, rx_byte} when the RX buffer is valid, else all ones
//   reg_dat_wait  high while a TX write is held off by a busy transmitter
module simple_uart #(
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StHalf = 4'd1,
    StBit0 = 4'd2,
    StBit1 = 4'd3,
    StBit2 = 4'd4,
    StBit3 = 4'd5,
    StBit4 = 4'd6,
    StBit5 = 4'd7,
    StBit6 = 4'd8,
    StBit7 = 4'd9,
    StStop = 4'd10
  } rx_state_e;

  logic [31:0] div_q;

  logic [9:0]  tx_pat_q;
  logic [3:0]  tx_bitcnt_q;
  logic [31:0] tx_divcnt_q;
  logic        tx_dummy_q;
  logic        tx_busy;
  logic        tx_bit_done;

  rx_state_e   rx_state_q;
  logic [31:0] rx_divcnt_q;
  logic [7:0]  rx_pat_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_bit_done;
  logic        rx_half_done;

  logic        unused_dat_di;
  assign unused_dat_di = ^reg_dat_di[31:8];

  // Divider register, byte-writable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 32'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) div_q[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  assign reg_div_do = div_q;

  // A bit ends on the cycle its counter has reached DIV, so each bit is DIV+1 clocks.
  assign tx_bit_done  = tx_divcnt_q >= div_q;
  assign rx_bit_done  = rx_divcnt_q >= div_q;
  // Half-bit point: 2*count > DIV, widened so the doubling cannot overflow.
  assign rx_half_done = {rx_divcnt_q, 1'b0} > {1'b0, div_q};

  assign tx_busy      = (tx_bitcnt_q != 4'd0) || tx_dummy_q;
  assign reg_dat_wait = reg_dat_we && tx_busy;
  assign ser_tx       = tx_pat_q[0];

  // Transmitter. A pending dummy frame (after reset or a DIV change) sends 15 idle-high
  // bit times so the far end sees a settled line at the new baud rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pat_q    <= '1;
      tx_bitcnt_q <= 4'd0;
      tx_divcnt_q <= 32'd0;
      tx_dummy_q  <= 1'b1;
    end else begin
      tx_divcnt_q <= tx_divcnt_q + 32'd1;
      if (tx_dummy_q && (tx_bitcnt_q == 4'd0)) begin
        tx_pat_q    <= '1;
        tx_bitcnt_q <= 4'd15;
        tx_divcnt_q <= 32'd0;
        tx_dummy_q  <= 1'b0;
      end else if (reg_dat_we && (tx_bitcnt_q == 4'd0)) begin
        tx_pat_q    <= {1'b1, reg_dat_di[7:0], 1'b0};
        tx_bitcnt_q <= 4'd10;
        tx_divcnt_q <= 32'd0;
      end else if ((tx_bitcnt_q != 4'd0) && tx_bit_done) begin
        tx_pat_q    <= {1'b1, tx_pat_q[9:1]};
        tx_bitcnt_q <= tx_bitcnt_q - 4'd1;
        tx_divcnt_q <= 32'd0;
      end
      // A DIV write always re-arms the dummy frame, even when one is being launched.
      if (|reg_div_we) tx_dummy_q <= 1'b1;
    end
  end

  // Receiver FSM. The start bit is not re-checked at mid-bit and the stop bit value is
  // ignored. A completing byte beats a same-cycle read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q  <= StIdle;
      rx_divcnt_q <= 32'd0;
      rx_pat_q    <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_divcnt_q <= rx_divcnt_q + 32'd1;
      if (reg_dat_re) rx_valid_q <= 1'b0;
      case (rx_state_q)
        StIdle: begin
          if (!ser_rx) begin
            rx_state_q  <= StHalf;
            rx_divcnt_q <= 32'd0;
          end
        end
        StHalf: begin
          if (rx_half_done) begin
            rx_state_q  <= StBit0;
            rx_divcnt_q <= 32'd0;
          end
        end
        StBit0, StBit1, StBit2, StBit3, StBit4, StBit5, StBit6, StBit7: begin
          if (rx_bit_done) begin
            rx_pat_q    <= {ser_rx, rx_pat_q[7:1]};
            rx_state_q  <= rx_state_e'(rx_state_q + 4'd1);
            rx_divcnt_q <= 32'd0;
          end
        end
        StStop: begin
          if (rx_bit_done) begin
            rx_data_q  <= rx_pat_q;
            rx_valid_q <= 1'b1;
            rx_state_q <= StIdle;
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  assign reg_dat_do = rx_valid_q ? {24'h0, rx_data_q} : 32'hFFFF_FFFF;

endmodule

// File: tb/tb_simple_uart.sv
module tb_simple_uart;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_tx;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  logic        rx_drv;
  logic        loopback;
  assign ser_rx = loopback ? ser_tx : rx_drv;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         bit_p    = 2;
  logic       mon_en   = 1'b1;
  logic       mon_busy = 1'b0;

  always #5 clk = ~clk;

  simple_uart #(
    .DEFAULT_DIV(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ser_tx      (ser_tx),
    .ser_rx      (ser_rx),
    .reg_div_we  (reg_div_we),
    .reg_div_di  (reg_div_di),
    .reg_div_do  (reg_div_do),
    .reg_dat_we  (reg_dat_we),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_di  (reg_dat_di),
    .reg_dat_do  (reg_dat_do),
    .reg_dat_wait(reg_dat_wait)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX monitor: samples every bit on its first and last cycle, so both the bit values
  // and the exact bit length are checked against the scoreboard entry.
  initial begin : tx_monitor
    logic [9:0] first_v;
    logic [9:0] last_v;
    logic [9:0] exp_f;
    @(negedge clk);
    forever begin
      if (mon_en && (reset === 1'b0) && (ser_tx === 1'b0)) begin
        mon_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
          for (int c = 0; c < bit_p; c++) begin
            if (c == 0) first_v[i] = ser_tx;
            if (c == bit_p - 1) last_v[i] = ser_tx;
            @(negedge clk);
          end
        end
        exp_f = 'x;
        if (tx_q.size() > 0) exp_f = {1'b1, tx_q.pop_front(), 1'b0};
        check("tx_frame_first", {22'h0, first_v}, {22'h0, exp_f});
        check("tx_frame_last", {22'h0, last_v}, {22'h0, exp_f});
        mon_busy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Presents a TX write and holds it until reg_dat_wait drops; returns the number of
  // negedges the write was stalled and whether ser_tx stayed high meanwhile.
  task automatic tx_write(input logic [7:0] b, input int budget, output int waited,
                          output logic all_high);
    @(negedge clk);
    reg_dat_di = {24'hDEADBE, b};
    reg_dat_we = 1'b1;
    #1;
    waited   = 0;
    all_high = 1'b1;
    while ((reg_dat_wait === 1'b1) && (waited < budget)) begin
      all_high = all_high & ser_tx;
      waited++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tx_release();
    @(negedge clk);
    reg_dat_we = 1'b0;
  endtask

  task automatic tx_drain(input int budget);
    int n;
    n = 0;
    while (((tx_q.size() != 0) || mon_busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic div_write(input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    reg_div_we = be;
    reg_div_di = d;
    @(negedge clk);
    reg_div_we = 4'h0;
  endtask

  // Drives one 8N1 frame on rx_drv with p cycles per bit; optionally pulses reg_dat_re
  // in frame cycle re_at (counted from the first start-bit cycle).
  task automatic rx_send(input logic [7:0] b, input int p, input int re_at);
    logic [9:0] frame;
    int         cyc;
    frame = {1'b1, b, 1'b0};
    cyc   = 0;
    rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        rx_drv     = frame[i];
        reg_dat_re = (cyc == re_at);
        cyc++;
      end
    end
    @(negedge clk);
    rx_drv     = 1'b1;
    reg_dat_re = 1'b0;
  endtask

  task automatic rx_expect(input string tag);
    logic [7:0] e;
    e = rx_q.pop_front();
    check(tag, reg_dat_do, {24'h0, e});
  endtask

  task automatic rx_read();
    @(negedge clk);
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
    check("rx_after_read", reg_dat_do, 32'hFFFF_FFFF);
  endtask

  initial begin : stimulus
    int   waited;
    int   n;
    logic hi;
    logic [7:0] lb_bytes [3];
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h80;

    reset      = 1'b1;
    reg_div_we = 4'h0;
    reg_div_di = 32'h0;
    reg_dat_we = 1'b0;
    reg_dat_re = 1'b0;
    reg_dat_di = 32'h0;
    rx_drv     = 1'b1;
    loopback   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ser_tx", {31'h0, ser_tx}, 32'h1);
    check("reset_dat_do", reg_dat_do, 32'hFFFF_FFFF);
    check("reset_div_do", reg_div_do, 32'h1);
    check("reset_wait", {31'h0, reg_dat_wait}, 32'h0);
    reset = 1'b0;

    // T1: the dummy frame holds the line high for 15 bits of 2 cycles before 0x55 goes out.
    bit_p = 2;
    tx_q.push_back(8'h55);
    tx_write(8'h55, 200, waited, hi);
    check("t1_dummy_stall", 32'(waited), 32'd30);
    check("t1_idle_high", {31'h0, hi}, 32'h1);
    tx_release();
    tx_drain(200);

    // T2: byte-wise DIV writes, then a 0xA3 frame at 105-cycle bits.
    div_write(4'b0001, 32'hAABB_CC68);
    check("t2_div_byte0", reg_div_do, 32'h0000_0068);
    div_write(4'b0010, 32'hFFFF_01FF);
    check("t2_div_byte1", reg_div_do, 32'h0000_0168);
    div_write(4'b0010, 32'h0000_0000);
    check("t2_div_back", reg_div_do, 32'h0000_0068);
    bit_p = 105;
    tx_q.push_back(8'hA3);
    tx_write(8'hA3, 10000, waited, hi);

    // T3: the next write is presented at once and stalls for the full 10-bit frame.
    tx_q.push_back(8'h5A);
    tx_write(8'h5A, 3000, waited, hi);
    check("t3_frame_stall", 32'(waited), 32'd1050);
    tx_release();
    #1;
    check("t3_wait_needs_we", {31'h0, reg_dat_wait}, 32'h0);
    tx_drain(3000);

    // T4: receive 0x3C at DIV=15, then consume it.
    div_write(4'b0001, 32'h0000_000F);
    check("t4_div", reg_div_do, 32'h0000_000F);
    check("t4_rx_empty", reg_dat_do, 32'hFFFF_FFFF);
    rx_send(8'h3C, 16, -1);
    rx_expect("t4_rx_3c");
    rx_read();

    // T5: unread bytes are overwritten; a byte completing with a read strobe survives.
    rx_send(8'h11, 16, -1);
    rx_expect("t5_rx_11");
    rx_send(8'h22, 16, -1);
    rx_expect("t5_rx_22");
    rx_send(8'h44, 16, 153);
    rx_expect("t5_rx_race");
    rx_read();

    // T6: loopback at DIV=3.
    loopback = 1'b1;
    div_write(4'b0001, 32'h0000_0003);
    check("t6_div", reg_div_do, 32'h0000_0003);
    bit_p = 4;
    for (int k = 0; k < 3; k++) begin
      tx_q.push_back(lb_bytes[k]);
      rx_q.push_back(lb_bytes[k]);
      tx_write(lb_bytes[k], 500, waited, hi);
      tx_release();
      n = 0;
      while ((reg_dat_do === 32'hFFFF_FFFF) && (n < 200)) begin
        @(negedge clk);
        n++;
      end
      rx_expect("t6_loopback");
      rx_read();
    end
    tx_drain(200);
    check("tx_drain", 32'(tx_q.size()), 32'd0);

    // Reset mid-frame: ser_tx rises without a clock edge and the RX frame is dropped.
    mon_en = 1'b0;
    tx_write(8'h00, 500, waited, hi);
    tx_release();
    #1;
    check("mid_start_bit", {31'h0, ser_tx}, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_tx", {31'h0, ser_tx}, 32'h1);
    check("mid_reset_div", reg_div_do, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_reset_rx", reg_dat_do, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
